// File: rtl/mem_port_arbiter.sv
// N-to-1 arbiter that serialises the core's memory ports onto the single-port
// memory_controller, one transaction at a time (round-robin or fixed priority).
module mem_port_arbiter #(
  parameter int PORT_COUNT = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2*PORT_COUNT-1:0]  rw_flag,
  input  logic [32*PORT_COUNT-1:0] addr,
  input  logic [32*PORT_COUNT-1:0] write_data,
  input  logic [4*PORT_COUNT-1:0]  write_mask,
  output logic [32*PORT_COUNT-1:0] read_data,
  output logic [PORT_COUNT-1:0]    busy,
  output logic [PORT_COUNT-1:0]    done,
  output logic [1:0]               m_rw_flag,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_write_data,
  output logic [3:0]               m_write_mask,
  input  logic [31:0]              m_read_data,
  input  logic                     m_busy,
  input  logic                     m_done
);

  localparam int GW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam logic [GW-1:0] LAST_PORT = GW'(PORT_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [GW-1:0]           win_s;
  logic [1:0]              rw_q, rw_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              mask_q, mask_d;
  logic [32*PORT_COUNT-1:0] read_data_q, read_data_d;
  logic [PORT_COUNT-1:0]   done_q, done_d;
  logic [PORT_COUNT-1:0]   elig_s;
  logic                    grant_ok_s;

  // 01 and 10 request a transfer; 00 and 11 are both "no request".
  always_comb begin
    for (int i = 0; i < PORT_COUNT; i++) begin
      elig_s[i] = rw_flag[2*i] ^ rw_flag[2*i+1];
    end
  end

  assign grant_ok_s = (|elig_s) & ~m_busy;

  // Winner selection; round-robin scans from last_grant+1, the last hit in
  // a descending scan is the first eligible port in search order.
  always_comb begin : p_winner
    logic [GW-1:0] idx;
    win_s = '0;
    idx   = '0;
    if (ARB_MODE == 1) begin
      for (int i = PORT_COUNT - 1; i >= 0; i--) begin
        win_s = elig_s[i] ? GW'(i) : win_s;
      end
    end else begin
      for (int k = PORT_COUNT; k >= 1; k--) begin
        idx   = GW'((int'(last_grant_q) + k) % PORT_COUNT);
        win_s = elig_s[idx] ? idx : win_s;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = grant_ok_s ? S_WAIT : S_IDLE;
      S_WAIT:  state_d = m_done ? S_DONE : S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; the request is latched at grant time so a
  // requester changing its inputs mid-transaction cannot disturb the controller.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    read_data_d  = read_data_q;
    done_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_ok_s) begin
          grant_d = win_s;
          rw_d    = rw_flag[{win_s, 1'b0} +: 2];
          addr_d  = addr[{win_s, 5'd0} +: 32];
          wdata_d = write_data[{win_s, 5'd0} +: 32];
          mask_d  = write_mask[{win_s, 2'd0} +: 4];
        end else begin
          rw_d = 2'b00;
        end
      end
      S_WAIT: begin
        if (m_done) begin
          rw_d                                 = 2'b00;
          done_d[grant_q]                      = 1'b1;
          read_data_d[{grant_q, 5'd0} +: 32]   = m_read_data;
        end else begin
          rw_d = rw_q;
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        rw_d         = 2'b00;
      end
      default: begin
        rw_d = 2'b00;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_q      <= '0;
      last_grant_q <= LAST_PORT;
      rw_q         <= 2'b00;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      mask_q       <= 4'h0;
      read_data_q  <= '0;
      done_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      read_data_q  <= read_data_d;
      done_q       <= done_d;
    end
  end

  // A port is busy only while it is requesting behind someone else's transfer.
  always_comb begin
    for (int i = 0; i < PORT_COUNT; i++) begin
      busy[i] = (state_q != S_IDLE) && (grant_q != GW'(i)) && elig_s[i];
    end
  end

  assign m_rw_flag    = rw_q;
  assign m_addr       = addr_q;
  assign m_write_data = wdata_q;
  assign m_write_mask = mask_q;
  assign read_data    = read_data_q;
  assign done         = done_q;

endmodule
